// File: rtl/proc_fetch_pkg.sv
// Shared types and constants for the F-stage fetch unit and its tag queue.
package proc_fetch_pkg;

  localparam logic [31:0] c_reset_vector = 32'h0000_0200;
  localparam logic [31:0] c_inst_nop     = 32'h0000_0013;

  typedef logic [31:0] fetch_tag_t;

  // Counter width able to hold 0..max_inflight inclusive.
  function automatic int unsigned inflight_cnt_w(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/proc_fetch_unit_if.sv
// Fetch unit boundary: redirect, imem request/response and the D-stage handshake.
interface proc_fetch_unit_if #(
  parameter int unsigned p_max_inflight = 2
);
  import proc_fetch_pkg::*;

  localparam int unsigned CntW = inflight_cnt_w(p_max_inflight);

  logic            redirect_val;
  logic [31:0]     redirect_target;
  logic            imem_req_val;
  logic            imem_req_rdy;
  logic [31:0]     imem_req_addr;
  logic            imem_resp_val;
  logic            imem_resp_rdy;
  logic [31:0]     imem_resp_data;
  logic            inst_val_D;
  logic            inst_rdy_D;
  logic [31:0]     inst_D;
  logic [31:0]     pc_D;
  logic [CntW-1:0] num_inflight;

  modport master (
    input  redirect_val, redirect_target, imem_req_rdy, imem_resp_val,
           imem_resp_data, inst_rdy_D,
    output imem_req_val, imem_req_addr, imem_resp_rdy, inst_val_D, inst_D,
           pc_D, num_inflight
  );

  modport slave (
    output redirect_val, redirect_target, imem_req_rdy, imem_resp_val,
           imem_resp_data, inst_rdy_D,
    input  imem_req_val, imem_req_addr, imem_resp_rdy, inst_val_D, inst_D,
           pc_D, num_inflight
  );

endinterface

// File: rtl/proc_fetch_tag_queue.sv
// Circular FIFO of fetch PCs, one entry per outstanding imem request.
module proc_fetch_tag_queue
  import proc_fetch_pkg::*;
#(
  parameter int unsigned p_depth = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  fetch_tag_t push_tag_i,
  input  logic       pop_i,
  output fetch_tag_t head_tag_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CntW = inflight_cnt_w(p_depth);

  fetch_tag_t      mem_q [p_depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CntW'(p_depth));
  assign head_tag_o = mem_q[head_q];

  // When full, a push is only legal alongside a pop; the head is read before it is overwritten.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    head_d = do_pop  ? ptr_inc(head_q) : head_q;
    tail_d = do_push ? ptr_inc(tail_q) : tail_q;
    cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_tag_i;
  end

endmodule

// File: rtl/proc_fetch_unit.sv
// F-stage front end: sequential PC generation, in-order imem tracking, redirect squash.
// Optional PROC_FETCH_STATS_EN adds num_fetched/num_dropped counters.
module proc_fetch_unit
  import proc_fetch_pkg::*;
#(
  parameter logic [31:0] p_reset_vector = c_reset_vector,
  parameter int unsigned p_max_inflight = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PROC_FETCH_STATS_EN
  output logic [31:0]       num_fetched,
  output logic [31:0]       num_dropped,
`endif
  proc_fetch_unit_if.master bus
);

  localparam int unsigned CntW = inflight_cnt_w(p_max_inflight);

  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            q_full, q_empty;
  fetch_tag_t      q_head;
  logic            req_fire, resp_fire, squash;

  // Request side: slot availability depends only on registered state.
  assign bus.imem_req_addr = bus.redirect_val ? bus.redirect_target : pc_q;
  assign bus.imem_req_val  = reset & (inflight_q < CntW'(p_max_inflight)) & ~q_full;
  assign req_fire          = bus.imem_req_val & bus.imem_req_rdy;

  // Response side: squashed responses are always drained, otherwise D provides backpressure.
  assign squash            = bus.redirect_val | (drop_q != '0);
  assign bus.imem_resp_rdy = reset & (squash | bus.inst_rdy_D);
  assign resp_fire         = bus.imem_resp_val & bus.imem_resp_rdy;

  assign bus.inst_val_D    = reset & bus.imem_resp_val & ~squash;
  assign bus.inst_D        = bus.imem_resp_data;
  assign bus.pc_D          = q_head;
  assign bus.num_inflight  = inflight_q;

  always_comb begin
    pc_d       = req_fire ? bus.imem_req_addr + 32'd4 : bus.imem_req_addr;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(resp_fire);
    if (bus.redirect_val) begin
      drop_d = inflight_q - CntW'(resp_fire);
    end else begin
      drop_d = drop_q - CntW'(resp_fire && (drop_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= p_reset_vector;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  proc_fetch_tag_queue #(
    .p_depth (p_max_inflight)
  ) u_tag_queue (
    .clk        (clk),
    .reset      (reset),
    .push_i     (req_fire),
    .push_tag_i (bus.imem_req_addr),
    .pop_i      (resp_fire),
    .head_tag_o (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

`ifdef PROC_FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] dropped_q, dropped_d;

  always_comb begin
    fetched_d = fetched_q + 32'(resp_fire & ~squash & bus.inst_rdy_D);
    dropped_d = dropped_q + 32'(resp_fire & squash);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
    end
  end

  assign num_fetched = fetched_q;
  assign num_dropped = dropped_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(bus.imem_resp_val && inflight_q == '0))
        else $error("imem response arrived with no request outstanding");
      assert (!(bus.redirect_val && bus.redirect_target[1:0] != 2'b00))
        else $error("redirect target is not word aligned");
      assert (!(q_empty && inflight_q != '0))
        else $error("tag queue empty while requests are outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Directed self-checking bench for proc_fetch_unit with a hand-driven imem and D stage.
module tb_proc_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  proc_fetch_unit_if #(.p_max_inflight(2)) bus ();

`ifdef PROC_FETCH_STATS_EN
  logic [31:0] num_fetched;
  logic [31:0] num_dropped;
`endif

  proc_fetch_unit #(
    .p_reset_vector (32'h0000_0200),
    .p_max_inflight (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef PROC_FETCH_STATS_EN
    .num_fetched (num_fetched),
    .num_dropped (num_dropped),
`endif
    .bus         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory returns for a given fetch address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b0;
    bus.redirect_val     = 1'b0;
    bus.redirect_target  = 32'h0;
    bus.imem_req_rdy     = 1'b0;
    bus.imem_resp_val    = 1'b0;
    bus.imem_resp_data   = 32'h0;
    bus.inst_rdy_D       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leaves 0x204 and 0x208 outstanding (0x200 already delivered); caller drives the next cycle.
  task automatic issue_two();
    @(negedge clk);
    bus.imem_req_rdy = 1'b1;
    @(negedge clk);
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h200);
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
    @(negedge clk);
    bus.imem_req_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.imem_req_rdy = 1'b1; bus.imem_resp_val = 1'b1; bus.imem_resp_data = 32'h1234_5678;
    @(negedge clk);
    #1;
    n_checks++; if (bus.imem_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_req_val: got %b want 0", bus.imem_req_val); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_resp_rdy: got %b want 0", bus.imem_resp_rdy); end
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rst_inst_val: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", bus.num_inflight); end
    bus.imem_resp_val = 1'b0; bus.imem_req_rdy = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL rst_first_req_val: got %b want 1", bus.imem_req_val); end
    n_checks++; if (bus.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rst_first_addr: got %h want 00000200", bus.imem_req_addr); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_resp_rdy_after: got %b want 1", bus.imem_resp_rdy); end
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_req, exp_pc;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_req = 32'h200 + 32'(4 * i);
      exp_pc  = 32'h200 + 32'(4 * (i - 1));
      bus.imem_req_rdy   = (i < 5);
      bus.imem_resp_val  = (i > 0);
      bus.imem_resp_data = inst_of(exp_pc);
      #1;
      n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL sl_req_val[%0d]: got %b want 1", i, bus.imem_req_val); end
      n_checks++; if (bus.imem_req_addr !== exp_req) begin n_fail++; $display("FAIL sl_req_addr[%0d]: got %h want %h", i, bus.imem_req_addr, exp_req); end
      n_checks++; if (bus.num_inflight !== ((i > 0) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL sl_inflight[%0d]: got %0d want %0d", i, bus.num_inflight, (i > 0) ? 1 : 0); end
      if (i > 0) begin
        n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL sl_inst_val[%0d]: got %b want 1", i, bus.inst_val_D); end
        n_checks++; if (bus.pc_D !== exp_pc) begin n_fail++; $display("FAIL sl_pc_D[%0d]: got %h want %h", i, bus.pc_D, exp_pc); end
        n_checks++; if (bus.inst_D !== inst_of(exp_pc)) begin n_fail++; $display("FAIL sl_inst_D[%0d]: got %h want %h", i, bus.inst_D, inst_of(exp_pc)); end
      end
    end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
    #1;
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL sl_drained: got %0d want 0", bus.num_inflight); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk); bus.imem_req_rdy = 1'b1;
    @(negedge clk); bus.imem_req_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.imem_req_rdy = 1'b1;
      bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h200);
      bus.inst_rdy_D = 1'b0;
      #1;
      n_checks++; if (bus.imem_req_val !== 1'b0) begin n_fail++; $display("FAIL bp_req_val[%0d]: got %b want 0", k, bus.imem_req_val); end
      n_checks++; if (bus.imem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_resp_rdy[%0d]: got %b want 0", k, bus.imem_resp_rdy); end
      n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL bp_inst_val[%0d]: got %b want 1", k, bus.inst_val_D); end
      n_checks++; if (bus.num_inflight !== 2'd2) begin n_fail++; $display("FAIL bp_inflight[%0d]: got %0d want 2", k, bus.num_inflight); end
    end
    @(negedge clk);
    bus.inst_rdy_D = 1'b1; bus.imem_req_rdy = 1'b0;
    #1;
    n_checks++; if (bus.imem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 1", bus.imem_resp_rdy); end
    n_checks++; if (bus.pc_D !== 32'h200) begin n_fail++; $display("FAIL bp_pc0: got %h want 00000200", bus.pc_D); end
    n_checks++; if (bus.inst_D !== 32'hC0DE0200) begin n_fail++; $display("FAIL bp_inst0: got %h want c0de0200", bus.inst_D); end
    @(negedge clk);
    bus.imem_resp_data = inst_of(32'h204);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL bp_inst_val1: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h204) begin n_fail++; $display("FAIL bp_pc1: got %h want 00000204", bus.pc_D); end
    n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL bp_req_resume: got %b want 1", bus.imem_req_val); end
    n_checks++; if (bus.imem_req_addr !== 32'h208) begin n_fail++; $display("FAIL bp_req_addr: got %h want 00000208", bus.imem_req_addr); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
    #1;
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", bus.num_inflight); end
  endtask

  task automatic test_redirect();
    do_reset();
    issue_two();
    bus.redirect_val = 1'b1; bus.redirect_target = 32'h300; bus.imem_req_rdy = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_val !== 1'b0) begin n_fail++; $display("FAIL rd_req_val: got %b want 0", bus.imem_req_val); end
    n_checks++; if (bus.imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rd_req_addr: got %h want 00000300", bus.imem_req_addr); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_resp_rdy: got %b want 1", bus.imem_resp_rdy); end
    @(negedge clk);
    bus.redirect_val = 1'b0;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h204);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rd_drop204: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_drain_rdy: got %b want 1", bus.imem_resp_rdy); end
    @(negedge clk);
    bus.imem_resp_data = inst_of(32'h208);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rd_drop208: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rd_new_addr: got %h want 00000300", bus.imem_req_addr); end
    n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL rd_new_val: got %b want 1", bus.imem_req_val); end
    @(negedge clk);
    bus.imem_req_rdy = 1'b0; bus.imem_resp_data = inst_of(32'h300);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL rd_deliver_val: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h300) begin n_fail++; $display("FAIL rd_deliver_pc: got %h want 00000300", bus.pc_D); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
    #1;
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL rd_drained: got %0d want 0", bus.num_inflight); end
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    issue_two();
    bus.redirect_val = 1'b1; bus.redirect_target = 32'h300; bus.imem_req_rdy = 1'b1;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h204);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rr_hide204: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_resp_rdy: got %b want 1", bus.imem_resp_rdy); end
    @(negedge clk);
    bus.redirect_val = 1'b0; bus.imem_resp_data = inst_of(32'h208);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rr_drop208: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rr_new_addr: got %h want 00000300", bus.imem_req_addr); end
    @(negedge clk);
    bus.imem_req_rdy = 1'b0; bus.imem_resp_data = inst_of(32'h300);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL rr_deliver_val: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h300) begin n_fail++; $display("FAIL rr_deliver_pc: got %h want 00000300", bus.pc_D); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_two();
    bus.redirect_val = 1'b1; bus.redirect_target = 32'h300; bus.imem_req_rdy = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_val !== 1'b0) begin n_fail++; $display("FAIL bb_req_val0: got %b want 0", bus.imem_req_val); end
    @(negedge clk);
    bus.redirect_target = 32'h400;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h204);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL bb_hide204: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL bb_addr400: got %h want 00000400", bus.imem_req_addr); end
    @(negedge clk);
    bus.redirect_val = 1'b0; bus.imem_resp_data = inst_of(32'h208);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL bb_drop208: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL bb_fetch400: got %h want 00000400", bus.imem_req_addr); end
    @(negedge clk);
    bus.imem_req_rdy = 1'b0; bus.imem_resp_data = inst_of(32'h400);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL bb_deliver_val: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h400) begin n_fail++; $display("FAIL bb_deliver_pc: got %h want 00000400", bus.pc_D); end
    n_checks++; if (bus.inst_D !== 32'hC0DE0400) begin n_fail++; $display("FAIL bb_deliver_inst: got %h want c0de0400", bus.inst_D); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
    #1;
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL bb_drained: got %0d want 0", bus.num_inflight); end
  endtask

  task automatic test_redirect_with_fire();
    do_reset();
    @(negedge clk);
    bus.imem_req_rdy = 1'b1;
    @(negedge clk);
    bus.redirect_val = 1'b1; bus.redirect_target = 32'h300;
    #1;
    n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL rf_req_val: got %b want 1", bus.imem_req_val); end
    n_checks++; if (bus.imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rf_req_addr: got %h want 00000300", bus.imem_req_addr); end
    @(negedge clk);
    bus.redirect_val = 1'b0; bus.imem_req_rdy = 1'b0;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h200);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL rf_drop200: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.num_inflight !== 2'd2) begin n_fail++; $display("FAIL rf_inflight: got %0d want 2", bus.num_inflight); end
    @(negedge clk);
    bus.imem_resp_data = inst_of(32'h300);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL rf_deliver_val: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h300) begin n_fail++; $display("FAIL rf_deliver_pc: got %h want 00000300", bus.pc_D); end
    n_checks++; if (bus.imem_req_addr !== 32'h304) begin n_fail++; $display("FAIL rf_next_addr: got %h want 00000304", bus.imem_req_addr); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    issue_two();
    reset = 1'b0;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h204);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b0) begin n_fail++; $display("FAIL mr_inst_val: got %b want 0", bus.inst_val_D); end
    n_checks++; if (bus.imem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL mr_resp_rdy: got %b want 0", bus.imem_resp_rdy); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0; bus.imem_req_rdy = 1'b1;
    #1;
    n_checks++; if (bus.num_inflight !== 2'd0) begin n_fail++; $display("FAIL mr_inflight: got %0d want 0", bus.num_inflight); end
    n_checks++; if (bus.imem_req_val !== 1'b0) begin n_fail++; $display("FAIL mr_req_val_rst: got %b want 0", bus.imem_req_val); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL mr_first_addr: got %h want 00000200", bus.imem_req_addr); end
    n_checks++; if (bus.imem_req_val !== 1'b1) begin n_fail++; $display("FAIL mr_first_val: got %b want 1", bus.imem_req_val); end
    @(negedge clk);
    bus.imem_req_rdy = 1'b0;
    bus.imem_resp_val = 1'b1; bus.imem_resp_data = inst_of(32'h200);
    #1;
    n_checks++; if (bus.inst_val_D !== 1'b1) begin n_fail++; $display("FAIL mr_deliver_val: got %b want 1", bus.inst_val_D); end
    n_checks++; if (bus.pc_D !== 32'h200) begin n_fail++; $display("FAIL mr_deliver_pc: got %h want 00000200", bus.pc_D); end
    @(negedge clk);
    bus.imem_resp_val = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.redirect_val    = 1'b0;
    bus.redirect_target = 32'h0;
    bus.imem_req_rdy    = 1'b0;
    bus.imem_resp_val   = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_rdy_D      = 1'b1;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_redirect_with_resp();
    test_back_to_back();
    test_redirect_with_fire();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_fetch_unit.md
Name: proc_fetch_unit

Overview:
- F-stage front end that sits directly upstream of the 5-stage datapath's D stage.
- Generates sequential fetch PCs, issues imem requests and tracks outstanding requests with a PC tag queue.
- Squashes stale responses after a redirect (branch or jal).
- Delivers {pc, inst} pairs to D over a val/rdy handshake.

Parameters:
- p_reset_vector, 32'h200, address of the first fetch after reset.
- p_max_inflight, 2, maximum outstanding imem requests (legal range 1..4).

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset (reset==0 resets)
- redirect_val  input  1  squash all in-flight fetches and restart at redirect_target
- redirect_target  input  32  new fetch PC
- imem_req_val  output  1  request valid
- imem_req_rdy  input  1  memory accepts request
- imem_req_addr  output  32  fetch address
- imem_resp_val  input  1  response valid (in order)
- imem_resp_rdy  output  1  unit accepts response
- imem_resp_data  input  32  instruction word
- inst_val_D  output  1  valid instruction to D
- inst_rdy_D  input  1  D accepts (reg_en_D)
- inst_D  output  32  instruction word to D
- pc_D  output  32  PC of inst_D
- num_inflight  output  $clog2(p_max_inflight+1)  outstanding request count

Behaviour:
- Reset (reset==0 at posedge):
  - pc_F <= p_reset_vector; inflight <= 0; drop_cnt <= 0; tag queue emptied.
  - While reset==0, all valid/ready outputs are 0.
- Fire definitions: req_fire = imem_req_val & imem_req_rdy; resp_fire = imem_resp_val & imem_resp_rdy.
- Request side:
  - imem_req_addr = redirect_val ? redirect_target : pc_F.
  - imem_req_val = (inflight < p_max_inflight) & tag queue not full. A response in the same cycle does not free a slot; there is no resp→req combinational path.
  - pc_F next = req_fire ? imem_req_addr+4 : (redirect_val ? redirect_target : pc_F).
  - On req_fire, imem_req_addr is pushed into the tag queue.
- Response side:
  - squash = redirect_val | (drop_cnt != 0).
  - imem_resp_rdy = squash ? 1 : inst_rdy_D.
  - inst_val_D = imem_resp_val & ~squash; inst_D = imem_resp_data; pc_D = tag queue head.
  - On resp_fire, the tag queue head is popped, whether the response is forwarded or dropped.
- Counters:
  - inflight next = inflight + req_fire - resp_fire. Wrap-around is impossible because the request limit bounds it.
  - drop_cnt next, on redirect_val: inflight - resp_fire. This covers every old request still outstanding. A request issued in the redirect cycle targets the new PC and is not counted.
  - drop_cnt next, otherwise: drop_cnt - (resp_fire & drop_cnt!=0).
- Simultaneous events:
  - Redirect in the same cycle as a response: the response is consumed and dropped, and is never visible to D.
  - Redirect while drop_cnt>0: recompute drop_cnt from inflight. Nothing is double-counted.
- Ordering: all latency is combinational. A response is forwarded in the cycle it arrives, and D sees zero added cycles.
- Protocol checks (SIM only): imem_resp_val with inflight==0 is an assertion error; redirect_target[1:0]!=0 is an assertion error.
- Reset mid-operation: all state clears. Responses to pre-reset requests are a system-level violation; the memory model is reset with the unit.

Optional Feature:
- Macro: PROC_FETCH_STATS_EN.
- With the macro defined:
  - Adds output ports num_fetched[31:0] and num_dropped[31:0].
  - num_fetched increments on each forwarded resp_fire & inst_rdy_D; num_dropped increments on each squashed resp_fire.
  - Both counters are cleared by reset and wrap at 2^32.
- Without the macro: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package proc_fetch_pkg:
  - c_reset_vector (32'h200), c_inst_nop (32'h00000013).
  - Typedef fetch_tag_t (32-bit PC).
  - Function computing the count width from p_max_inflight.
- One sub-module, proc_fetch_tag_queue:
  - Circular FIFO of depth p_max_inflight with head/tail pointers and a count.
  - Provides push/pop/full/empty.
  - Supports simultaneous push and pop when full.

Test Plan:
- Straight-line fetch: memory with 1-cycle latency, always ready → requests at 0x200, 0x204, 0x208…; D receives matching pc_D/inst_D pairs in order; num_inflight never exceeds 2.
- Backpressure: inst_rdy_D=0 for 5 cycles with 2 in flight → imem_req_val=0; imem_resp_rdy=0; on release, D receives 0x200 then 0x204 with no loss.
- Redirect with 2 in flight (0x204, 0x208): redirect_val=1, target 0x300 → drop_cnt=2; both responses dropped; next inst_val_D carries pc_D=0x300.
- Redirect in the same cycle as response 0x204 → 0x204 not forwarded; drop_cnt=1; then 0x300 delivered.
- Back-to-back redirects (0x300, then 0x400 the next cycle) → only pc_D=0x400 stream reaches D.
- Reset (reset=0) asserted mid-stream with 2 in flight → next cycle num_inflight=0, inst_val_D=0; first request after release at 0x200.
